// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fixup.
module muldiv_negate #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic [W-1:0] val_o
);

  assign val_o = en_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Magnitudes are computed on entry; signs are restored in the FIX state.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned W2 = 2 * W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dzp_q, dzp_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;

  logic             is_div_op, signed_op, b_zero, a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;
  logic [W-1:0]     prod_hi, prod_lo, hi_fix, lo_fix;
  logic             hi_neg_en;
  logic [W:0]       mul_sum;
  logic             div_ge;
  logic [W-1:0]     div_diff;

  assign is_div_op = (op == OP_DIVU) || (op == OP_DIV);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign b_zero    = (b == '0);
  assign a_neg     = signed_op & a[W-1];
  assign b_neg     = signed_op & b[W-1];

  muldiv_negate #(.W(W)) u_neg_a (.val_i(a), .en_i(a_neg), .val_o(a_mag));
  muldiv_negate #(.W(W)) u_neg_b (.val_i(b), .en_i(b_neg), .val_o(b_mag));

  assign prod_hi = prod_q[W2-1:W];
  assign prod_lo = prod_q[W-1:0];

  // Multiply: prod = {partial, multiplier}; add multiplicand on LSB, shift right.
  assign mul_sum = {1'b0, prod_hi} + {1'b0, ({W{prod_q[0]}} & opb_q)};

  // Divide: prod = {remainder, dividend}; trial-subtract the shifted remainder.
  assign div_ge   = prod_q[W2-1:W-1] >= {1'b0, opb_q};
  assign div_diff = prod_q[W2-2:W-1] - opb_q;

  assign hi_neg_en = is_div_q ? rneg_q : neg_q;

  muldiv_negate #(.W(W)) u_neg_lo (.val_i(prod_lo), .en_i(neg_q),     .val_o(lo_fix));
  muldiv_negate #(.W(W)) u_neg_hi (.val_i(prod_hi), .en_i(hi_neg_en), .val_o(hi_fix));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (is_div_op && b_zero) ? S_FIX : S_CALC;
      S_CALC:  if (cnt_q == CNT_W'(W - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dzp_d    = dzp_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    busy_d   = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d    = '0;
          is_div_d = is_div_op;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          dzp_d    = 1'b0;
          if (is_div_op && b_zero) begin
            // Sign fixup disabled so FIX commits hi=a, lo=all ones verbatim.
            prod_d = {a, {W{1'b1}}};
            neg_d  = 1'b0;
            rneg_d = 1'b0;
            dzp_d  = 1'b1;
          end else if (is_div_op) begin
            prod_d = {{W{1'b0}}, a_mag};
            opb_d  = b_mag;
          end else begin
            prod_d = {{W{1'b0}}, b_mag};
            opb_d  = a_mag;
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!is_div_q)   prod_d = {mul_sum, prod_q[W-1:1]};
        else if (div_ge) prod_d = {div_diff, prod_q[W-2:0], 1'b1};
        else             prod_d = {prod_q[W2-2:0], 1'b0};
      end
      S_FIX: begin
        done_d = 1'b1;
        dz_d   = dzp_q;
        lo_d   = lo_fix;
        // 2W-bit negation: high word is inverted, plus one only when the low word is zero.
        hi_d   = (!is_div_q && neg_q && (prod_lo != '0)) ? ~prod_hi : hi_fix;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      prod_q   <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dzp_q    <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dzp_q    <= dzp_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at W=32.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge; returns edges from accept to done (-1 on timeout).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit poke, output int lat, output int bcnt, output logic dzs);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    lat  = -1;
    bcnt = busy ? 1 : 0;
    dzs  = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (poke && k == 5) begin
        start = 1'b1; op = OP_DIVU; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1234;
      end
      if (poke && k == 6) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        dzs = dz;
        break;
      end
    end
  endtask

  int   lat, bcnt, ndone;
  logic dzs;

  initial begin
    // Reset with competing start and write strobes
    rst = 1'b1; start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz",   32'(dz),   32'd0);
    check("rst_hi",   hi, 32'd0);
    check("rst_lo",   lo, 32'd0);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; rst = 1'b0;
    @(negedge clk);

    // MULTU max*max with start and writes poked mid-CALC
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, bcnt, dzs);
    check("multu_lat",  32'(lat),  32'd33);
    check("multu_busy", 32'(bcnt), 32'd33);
    check("multu_hi",   hi, 32'hFFFF_FFFE);
    check("multu_lo",   lo, 32'h0000_0001);
    check("multu_dz",   32'(dzs), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("busy_idle",  32'(busy), 32'd0);
    check("hi_hold",    hi, 32'hFFFF_FFFE);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, lat, bcnt, dzs);
    check("mult_lat", 32'(lat), 32'd33);
    check("mult_hi",  hi, 32'hFFFF_FFFF);
    check("mult_lo",  lo, 32'hFFFF_FFF1);

    run_op(OP_MULT, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0, lat, bcnt, dzs);
    check("mult_nn_hi", hi, 32'h0000_0000);
    check("mult_nn_lo", lo, 32'h0000_0040);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bcnt, dzs);
    check("div_lat", 32'(lat), 32'd33);
    check("div_lo",  lo, 32'hFFFF_FFFD);
    check("div_hi",  hi, 32'hFFFF_FFFF);

    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, bcnt, dzs);
    check("div_pn_lo", lo, 32'hFFFF_FFFD);
    check("div_pn_hi", hi, 32'h0000_0001);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcnt, dzs);
    check("div_wrap_lo", lo, 32'h8000_0000);
    check("div_wrap_hi", hi, 32'h0000_0000);
    check("div_wrap_dz", 32'(dzs), 32'd0);

    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, lat, bcnt, dzs);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    run_op(OP_DIVU, 32'd100, 32'd0, 1'b0, lat, bcnt, dzs);
    check("dz_lat", 32'(lat), 32'd1);
    check("dz_flag", 32'(dzs), 32'd1);
    check("dz_hi", hi, 32'h0000_0064);
    check("dz_lo", lo, 32'hFFFF_FFFF);

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo", lo, 32'hFFFF_FFFF);
    lo_we = 1'b1; wdata = 32'h0000_5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h0000_5678);

    // start wins over a simultaneous lo write
    op = OP_MULTU; a = 32'd7; b = 32'd9; start = 1'b1; lo_we = 1'b1; wdata = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    check("start_lowe_lo", lo, 32'h0000_5678);
    check("start_busy", 32'(busy), 32'd1);
    ndone = 0;
    for (int k = 0; k < 40 && ndone == 0; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("start_lowe_done", 32'(ndone), 32'd1);
    check("start_lowe_res", lo, 32'd63);
    check("start_lowe_hi",  hi, 32'd0);

    // Reset mid-operation abandons the result
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_0011;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    op = OP_MULTU; a = 32'd7; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_hi",   hi, 32'd0);
    check("midrst_lo",   lo, 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_nodone", 32'(ndone), 32'd0);
    check("midrst_lo_hold", lo, 32'd0);

    run_op(OP_MULTU, 32'd7, 32'd9, 1'b0, lat, bcnt, dzs);
    check("after_rst_lat", 32'(lat), 32'd33);
    check("after_rst_lo",  lo, 32'd63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
